// File: rtl/serial_frame_feeder.sv
// rtl/serial_frame_feeder.sv - serializes a parallel frame into a bidirectional shift register
// Zero-fill follows the data so the last bits propagate through the downstream stages.
module serial_frame_feeder #(
  parameter int WIDTH        = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sel_out,
  output logic             shifting,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic             sout_q, sout_d;
  logic             sel_q, sel_d;
  logic             shifting_q, shifting_d;
  logic             done_q, done_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      flush_cnt_q <= '0;
      sout_q      <= 1'b0;
      sel_q       <= 1'b0;
      shifting_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      sout_q      <= sout_d;
      sel_q       <= sel_d;
      shifting_q  <= shifting_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    flush_cnt_d = flush_cnt_q;
    sout_d      = sout_q;
    sel_d       = sel_q;
    shifting_d  = shifting_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d    = din;
          sel_d      = dir;
          sout_d     = dir ? din[WIDTH-1] : din[0];
          bit_cnt_d  = '0;
          shifting_d = 1'b1;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          sout_d      = 1'b0;
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          // Shift register walks toward the bit already presented, exposing the next one.
          if (sel_q) begin
            sout_d  = shreg_q[WIDTH-2];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            sout_d  = shreg_q[1];
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
        end
      end

      FLUSH: begin
        sout_d = 1'b0;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d    = IDLE;
          shifting_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FLUSH_ONE;
        end
      end

      default: begin
        state_d    = IDLE;
        sout_d     = 1'b0;
        shifting_d = 1'b0;
      end
    endcase
  end

  assign load_ready = (state_q == IDLE);
  assign sout       = sout_q;
  assign sel_out    = sel_q;
  assign shifting   = shifting_q;
  assign done       = done_q;

endmodule
